// File: rtl/step_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : step_cmd_sequencer_if
// Description : Valid/ready command channel between the step command
//               sequencer (master) and the BCD counter datapath (slave).
//               Signals:
//                 cmd_valid  master->slave  command offered
//                 cmd_op     master->slave  00 CLR, 01 INC1, 10 INC2
//                 cmd_ready  slave->master  datapath accepts command
//               A command transfers at a rising clock edge where
//               cmd_valid && cmd_ready.
// Revision    : 1.0  initial release
// ============================================================================
interface step_cmd_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface : step_cmd_sequencer_if
`default_nettype wire

// File: rtl/step_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : step_cmd_sequencer
// Description : Control block for the two-digit BCD step counter. Merges the
//               periodic tick, manual single-step presses and parity mode
//               changes into one command stream (CLR / INC1 / INC2) over a
//               valid/ready channel. Issues one CLR after reset, then keeps
//               the units digit on the selected parity by choosing +1 or +2.
// Ports       :
//   clock       in   system clock
//   reset       in   synchronous, active-low reset
//   run_en      in   1 = periodic ticks generate steps
//   parity_sel  in   0 = even sequence, 1 = odd sequence
//   step_key_n  in   manual step pushbutton, active-low, asynchronous
//   bcd0_lsb    in   bit 0 of the datapath units digit
//   cmd         if   master side of the command channel
//   tick        out  one-cycle prescaler pulse (debug)
//   state       out  FSM state: 00 INIT, 01 IDLE, 10 ISSUE
// Revision    : 1.0  initial release
// ============================================================================
module step_cmd_sequencer #(
    parameter int TICK_DIV = 50000000,  // clock cycles per tick period (>= 2)
    parameter int TICK_W   = 26         // prescaler width, 2^TICK_W >= TICK_DIV
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             run_en,
    input  wire logic             parity_sel,
    input  wire logic             step_key_n,
    input  wire logic             bcd0_lsb,
    step_cmd_sequencer_if.master  cmd,
    output logic                  tick,
    output logic [1:0]            state
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_ST_INIT  = 2'b00;
    localparam logic [1:0] C_ST_IDLE  = 2'b01;
    localparam logic [1:0] C_ST_ISSUE = 2'b10;

    localparam logic [1:0] C_OP_CLR   = 2'b00;
    localparam logic [1:0] C_OP_INC1  = 2'b01;
    localparam logic [1:0] C_OP_INC2  = 2'b10;

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [TICK_W-1:0] presc_q, presc_d;
    logic              key_s1_q, key_s2_q, key_prev_q;
    logic              step_pend_q, step_pend_d;
    logic              align_pend_q, align_pend_d;
    logic              parity_q;
    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              own_step_q, own_step_d;   // 1 = in-flight command is a STEP

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_tick;
    logic w_press;
    logic w_valid;
    logic w_xfer;
    logic w_step_evt;
    logic w_step_done;
    logic w_par_chg;
    logic w_load_align;   // IDLE decides to issue an ALIGN (INC1)
    logic w_load_step;    // IDLE decides to issue a STEP
    logic w_align_drop;   // IDLE finds parity already correct, no command

    // ------------------------------------------------------------------------
    // Prescaler: free-running 0..TICK_DIV-1, independent of run_en. The tick
    // is decoded from the count so it lines up with count==TICK_DIV-1.
    // ------------------------------------------------------------------------
    assign w_tick  = (presc_q == C_TICK_LAST);

    always_comb begin
        presc_d = presc_q + TICK_W'(1);
        if (w_tick) begin
            presc_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Key input: key_s1/key_s2 synchronize the asynchronous button; key_prev
    // holds the previous synchronized value so a press is its 1->0 edge.
    // ------------------------------------------------------------------------
    assign w_press = key_prev_q & ~key_s2_q;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign w_xfer = w_valid & cmd.cmd_ready;

    // ------------------------------------------------------------------------
    // Pending flags. An event arriving in the same cycle as the clear wins,
    // so nothing is lost at the transfer edge.
    // ------------------------------------------------------------------------
    assign w_step_evt  = (w_tick & run_en) | w_press;
    assign w_step_done = w_xfer & (state_q == C_ST_ISSUE) & own_step_q;
    assign w_par_chg   = parity_sel ^ parity_q;

    always_comb begin
        step_pend_d  = w_step_evt | (step_pend_q & ~w_step_done);
        // The align request is retired when IDLE evaluates it, so a parity
        // change arriving while an ALIGN is in ISSUE is re-evaluated later.
        align_pend_d = w_par_chg | (align_pend_q & ~(w_load_align | w_align_drop));
    end

    // ------------------------------------------------------------------------
    // Command latch: op and owner are captured on entry to ISSUE and held
    // while cmd_valid is high, so late parity changes cannot alter them.
    // ------------------------------------------------------------------------
    always_comb begin
        op_d       = op_q;
        own_step_d = own_step_q;
        if (w_load_align) begin
            op_d       = C_OP_INC1;
            own_step_d = 1'b0;
        end else if (w_load_step) begin
            // Already on the target parity: +2 keeps it; otherwise +1 moves onto it.
            op_d       = (bcd0_lsb == parity_q) ? C_OP_INC2 : C_OP_INC1;
            own_step_d = 1'b1;
        end
        if (state_d == C_ST_INIT) begin
            op_d       = C_OP_CLR;
            own_step_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Non-FSM registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q      <= '0;
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            key_prev_q   <= 1'b1;
            step_pend_q  <= 1'b0;
            align_pend_q <= 1'b0;
            parity_q     <= parity_sel;
            op_q         <= C_OP_CLR;
            own_step_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            key_s1_q     <= step_key_n;
            key_s2_q     <= key_s1_q;
            key_prev_q   <= key_s2_q;
            step_pend_q  <= step_pend_d;
            align_pend_q <= align_pend_d;
            parity_q     <= parity_sel;
            op_q         <= op_d;
            own_step_q   <= own_step_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= C_ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next state and IDLE decisions. Alignment outranks a
    // pending step so the parity is corrected before counting resumes.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        w_load_align = 1'b0;
        w_load_step  = 1'b0;
        w_align_drop = 1'b0;
        case (state_q)
            C_ST_INIT: begin
                if (w_xfer) begin
                    state_d = C_ST_IDLE;
                end
            end
            C_ST_IDLE: begin
                if (align_pend_q) begin
                    if (bcd0_lsb != parity_q) begin
                        w_load_align = 1'b1;
                        state_d      = C_ST_ISSUE;
                    end else begin
                        w_align_drop = 1'b1;
                    end
                end else if (step_pend_q) begin
                    w_load_step = 1'b1;
                    state_d     = C_ST_ISSUE;
                end
            end
            C_ST_ISSUE: begin
                if (w_xfer) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs. cmd_valid is masked while reset is low so a
    // command can never transfer on the reset edge; the channel restarts
    // cleanly with CLR from INIT.
    // ------------------------------------------------------------------------
    always_comb begin
        w_valid       = reset & ((state_q == C_ST_INIT) | (state_q == C_ST_ISSUE));
        cmd.cmd_valid = w_valid;
        cmd.cmd_op    = op_q;
        tick          = w_tick;
        state         = state_q;
    end

endmodule : step_cmd_sequencer
`default_nettype wire

// File: tb/tb_step_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_cmd_sequencer
// Description : Directed self-checking bench for step_cmd_sequencer with a
//               4-cycle tick period. Inputs change 2 time units after each
//               rising edge and outputs are sampled 1 unit later.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_step_cmd_sequencer;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 2;

    logic       clock;
    logic       reset;
    logic       run_en;
    logic       parity_sel;
    logic       step_key_n;
    logic       bcd0_lsb;
    logic       tick;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    step_cmd_sequencer_if u_if ();

    step_cmd_sequencer #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_en     (run_en),
        .parity_sel (parity_sel),
        .step_key_n (step_key_n),
        .bcd0_lsb   (bcd0_lsb),
        .cmd        (u_if),
        .tick       (tick),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic clk();
        @(posedge clock);
        #2;
    endtask

    // One reset edge; returns 1 unit into cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b0;
        clk();
        reset = 1'b1;
        #1;
    endtask

    // Walks cycles 0..n-1 after reset with ready=1. Commands expected: CLR in
    // cycle 0, then step_op at cycles 5, 9, 13 (tick at 3, 7, 11 plus two
    // cycles), unless run_en was dropped after cycle run_off_at.
    task automatic check_cycles(input string tag, input int n,
                                input logic [1:0] step_op, input int run_off_at);
        logic       exp_valid;
        logic [1:0] exp_state;
        for (int c = 0; c < n; c++) begin
            exp_valid = (c == 0) || ((c >= 5) && ((c - 5) % 4 == 0) && (c <= run_off_at + 2));
            exp_state = (c == 0) ? 2'b00 : (exp_valid ? 2'b10 : 2'b01);
            chk({tag, "_tick"},  {7'd0, tick},          {7'd0, (c % 4 == 3)});
            chk({tag, "_valid"}, {7'd0, u_if.cmd_valid}, {7'd0, exp_valid});
            chk({tag, "_state"}, {6'd0, state},          {6'd0, exp_state});
            if (exp_valid) begin
                chk({tag, "_op"}, {6'd0, u_if.cmd_op}, (c == 0) ? 8'h00 : {6'd0, step_op});
            end
            if (c == run_off_at) run_en = 1'b0;
            clk();
            #1;
        end
    endtask

    int         ncmd;
    logic [1:0] last_op;

    initial begin
        reset          = 1'b0;
        run_en         = 1'b0;
        parity_sel     = 1'b0;
        step_key_n     = 1'b1;
        bcd0_lsb       = 1'b0;
        u_if.cmd_ready = 1'b1;
        clk();

        // ---- 1: reset release, CLR accepted, then IDLE --------------------
        do_reset();
        chk("t1_valid0", {7'd0, u_if.cmd_valid}, 8'h01);
        chk("t1_op0",    {6'd0, u_if.cmd_op},    8'h00);
        chk("t1_state0", {6'd0, state},          8'h00);
        chk("t1_tick0",  {7'd0, tick},           8'h00);
        clk(); #1;
        chk("t1_state1", {6'd0, state},          8'h01);
        chk("t1_valid1", {7'd0, u_if.cmd_valid}, 8'h00);

        // ---- 2: even parity, even digit -> INC2 every tick ----------------
        run_en = 1'b1; parity_sel = 1'b0; bcd0_lsb = 1'b0;
        do_reset();
        check_cycles("t2", 14, 2'b10, 99);

        // ---- 3: odd digit -> INC1; then run_en=0 -> ticks only ------------
        run_en = 1'b1; bcd0_lsb = 1'b1;
        do_reset();
        check_cycles("t3", 25, 2'b01, 13);

        // ---- 4: parity change alignment ----------------------------------
        // Digit odd, switch to odd: already aligned, flag retires silently.
        parity_sel = 1'b1;
        clk(); #1;
        chk("t4a_align_set", {7'd0, dut.align_pend_q}, 8'h01);
        chk("t4a_valid_c1",  {7'd0, u_if.cmd_valid},   8'h00);
        clk(); #1;
        chk("t4a_align_clr", {7'd0, dut.align_pend_q}, 8'h00);
        chk("t4a_valid_c2",  {7'd0, u_if.cmd_valid},   8'h00);
        chk("t4a_state_c2",  {6'd0, state},            8'h01);
        // Digit odd, switch to even: one INC1 two cycles later.
        parity_sel = 1'b0;
        clk(); #1;
        chk("t4b_valid_c1",  {7'd0, u_if.cmd_valid},   8'h00);
        clk(); #1;
        chk("t4b_valid_c2",  {7'd0, u_if.cmd_valid},   8'h01);
        chk("t4b_op_c2",     {6'd0, u_if.cmd_op},      8'h01);
        chk("t4b_state_c2",  {6'd0, state},            8'h02);
        bcd0_lsb = 1'b0;   // datapath digit is now even
        clk(); #1;
        chk("t4b_valid_c3",  {7'd0, u_if.cmd_valid},   8'h00);
        chk("t4b_state_c3",  {6'd0, state},            8'h01);
        clk(); clk(); #1;
        chk("t4b_valid_c5",  {7'd0, u_if.cmd_valid},   8'h00);

        // ---- 5: stall on CLR with ticks and three presses ----------------
        run_en = 1'b1; parity_sel = 1'b0; bcd0_lsb = 1'b0;
        u_if.cmd_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            chk("t5_stall_valid", {7'd0, u_if.cmd_valid}, 8'h01);
            chk("t5_stall_op",    {6'd0, u_if.cmd_op},    8'h00);
            if (c == 2 || c == 5 || c == 8) step_key_n = 1'b0;
            if (c == 4 || c == 7 || c == 10) step_key_n = 1'b1;
            clk(); #1;
        end
        u_if.cmd_ready = 1'b1; run_en = 1'b0;
        #1;
        chk("t5_clr_valid", {7'd0, u_if.cmd_valid}, 8'h01);
        chk("t5_clr_op",    {6'd0, u_if.cmd_op},    8'h00);
        ncmd = 0;
        last_op = 2'b11;
        for (int c = 0; c < 10; c++) begin
            clk(); #1;
            if (u_if.cmd_valid) begin
                ncmd++;
                last_op = u_if.cmd_op;
            end
        end
        chk("t5_step_count", ncmd[7:0],        8'h01);
        chk("t5_step_op",    {6'd0, last_op},  8'h02);
        chk("t5_step_pend",  {7'd0, dut.step_pend_q}, 8'h00);

        // ---- 6: reset while in ISSUE -------------------------------------
        u_if.cmd_ready = 1'b0;
        step_key_n = 1'b0;
        clk(); clk();
        step_key_n = 1'b1;
        for (int i = 0; i < 10 && state !== 2'b10; i++) clk();
        #1;
        chk("t6_reach_issue", {6'd0, state}, 8'h02);
        reset = 1'b0;
        #1;
        chk("t6_valid_drop", {7'd0, u_if.cmd_valid}, 8'h00);
        clk();
        reset = 1'b1;
        #1;
        chk("t6_state",  {6'd0, state},             8'h00);
        chk("t6_op",     {6'd0, u_if.cmd_op},       8'h00);
        chk("t6_valid",  {7'd0, u_if.cmd_valid},    8'h01);
        chk("t6_step_p", {7'd0, dut.step_pend_q},   8'h00);
        chk("t6_algn_p", {7'd0, dut.align_pend_q},  8'h00);

        // Narrow key pulse spanning exactly one edge -> exactly one STEP.
        u_if.cmd_ready = 1'b1;
        clk(); clk();
        #6;
        step_key_n = 1'b0;
        @(posedge clock);
        #2;
        step_key_n = 1'b1;
        ncmd = 0;
        last_op = 2'b11;
        for (int c = 0; c < 12; c++) begin
            clk(); #1;
            if (u_if.cmd_valid) begin
                ncmd++;
                last_op = u_if.cmd_op;
            end
        end
        chk("t6_narrow_count", ncmd[7:0],       8'h01);
        chk("t6_narrow_op",    {6'd0, last_op}, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_step_cmd_sequencer
`default_nettype wire

// File: doc/step_cmd_sequencer.md
Name: step_cmd_sequencer

Overview:
- Control block that sequences the two-digit BCD step counter datapath.
- Merges three event sources into a single command stream over a valid/ready handshake to the counter datapath: the periodic 1 s tick, manual single-step presses, and parity (even/odd) mode changes.
- Issues one clear after reset. Selects +1 or +2 steps so the units digit lands on and stays on the selected parity.
- The datapath only executes commands; this block owns timing and policy.

Parameters:
TICK_DIV, 50000000, clock cycles per tick period (minimum 2)
TICK_W, 26, prescaler width (2^TICK_W >= TICK_DIV)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
run_en  in  1  1 = periodic ticks generate steps
parity_sel  in  1  0 = even sequence, 1 = odd sequence
step_key_n  in  1  manual step pushbutton, active-low, asynchronous
bcd0_lsb  in  1  bit 0 of the datapath units digit
cmd_valid  out  1  command offered
cmd_op  out  2  00 CLR, 01 INC1, 10 INC2 (11 never driven)
cmd_ready  in  1  datapath accepts command
tick  out  1  one-cycle prescaler pulse (debug)
state  out  2  FSM state: 00 INIT, 01 IDLE, 10 ISSUE

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clock.
- Reset (reset=0 at a clock edge) sets:
  - prescaler=0, tick=0
  - step_pend=0, align_pend=0
  - parity_q=parity_sel
  - key sync flops=1
  - state=INIT, cmd_valid=1, cmd_op=CLR
- Prescaler:
  - Free-running 0..TICK_DIV-1, independent of run_en.
  - tick=1 exactly in the cycle where count==TICK_DIV-1, then count wraps to 0.
  - First tick occurs TICK_DIV cycles after reset release.
- Key input: two-flop synchronizer; a press is a 1->0 transition of the synchronized value. No debounce; that is upstream.
- Transfer: cmd_valid && cmd_ready at a rising edge. cmd_op is latched on entry to ISSUE/INIT and is stable while cmd_valid=1.
- step_pend:
  - Set at the edge after (tick && run_en) or a key press. Presses work regardless of run_en.
  - Holds at most one event; further events while set are dropped.
  - Cleared on transfer of a STEP command, except that an event in the same cycle keeps it set (set wins).
- align_pend:
  - Set at any edge where parity_sel != parity_q; parity_q<=parity_sel at that edge.
  - Cleared when the align decision is made in IDLE. Set wins on the same-edge rule.
- FSM:
  - INIT: cmd_valid=1, op=CLR; on transfer go to IDLE.
  - IDLE: cmd_valid=0. Priority is align_pend, then step_pend.
    - align_pend with bcd0_lsb!=parity_q: latch INC1 (ALIGN), go to ISSUE.
    - align_pend with bcd0_lsb==parity_q: clear align_pend, stay IDLE for one cycle.
    - else step_pend: latch INC2 if bcd0_lsb==parity_q, else INC1 (STEP); go to ISSUE.
  - ISSUE: cmd_valid=1; on transfer clear the pend flag owning the command, go to IDLE.
  - Parity changes during ISSUE do not alter the latched op.
- Latency: tick at cycle T -> step_pend=1 at T+1 -> state ISSUE / cmd_valid=1 at T+2. With cmd_ready=1, transfer occurs at the end of T+2 and state is IDLE at T+3.
- Minimum spacing between commands is 2 cycles (IDLE between ISSUEs).
- bcd0_lsb must reflect the datapath after the previous command; the datapath updates on the transfer edge.
- Reset mid-handshake: cmd_valid drops and is reasserted as CLR from the next cycle (INIT). No partial command semantics.

Test Plan:
1. Release reset with cmd_ready=1 -> cycle 0: cmd_valid=1, cmd_op=00, state=00; cycle 1: state=01, cmd_valid=0.
2. TICK_DIV=4, run_en=1, parity_sel=0, bcd0_lsb=0, ready=1 -> INC2 (10) transfer every 4 cycles, first transfer 6 cycles after reset release (after the CLR); tick pulses at counts 3, 7, 11.
3. As in 2 with bcd0_lsb=1 -> each transfer is INC1 (01). run_en=0 -> no commands, tick still pulses.
4. In IDLE, parity_sel 0->1 with bcd0_lsb=0, no tick -> exactly one INC1 issued 2 cycles later. Repeat with bcd0_lsb=1 -> no command, align_pend clears.
5. cmd_ready=0 for 12 cycles with ticks and 3 key presses -> cmd_valid stays 1 and cmd_op stays constant. After ready=1: one transfer, then exactly one more STEP, then idle.
6. Assert reset for one cycle while state=ISSUE -> next cycle state=00, cmd_op=00, pending flags 0. Key pulse narrower than 2 cycles is still detected once if it spans one clock edge low in the synchronized domain.
